// File: rtl/mem_bus_bridge_pkg.sv
// mem_bus_bridge_pkg: shared FSM encoding, strobe width and access-fault cause mapping
package mem_bus_bridge_pkg;
    localparam int WSTRB_WIDTH = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [3:0] {
        CAUSE_INSTR_FAULT = 4'd1,
        CAUSE_LOAD_FAULT  = 4'd5,
        CAUSE_STORE_FAULT = 4'd7
    } fault_cause_t;
    function automatic fault_cause_t fault_cause(input logic fetch, input logic [WSTRB_WIDTH-1:0] wstrb);
        return fetch ? CAUSE_INSTR_FAULT : (|wstrb) ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
    endfunction
endpackage

// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: valid/ready request channel between the bridge and the SoC interconnect
interface mem_bus_bridge_if;
    import mem_bus_bridge_pkg::*;
    logic                   bus_valid;
    logic                   bus_ready;
    logic [31:0]            bus_addr;
    logic [31:0]            bus_wdata;
    logic [31:0]            bus_rdata;
    logic [WSTRB_WIDTH-1:0] bus_wstrb;
    modport master (output bus_valid, bus_addr, bus_wdata, bus_wstrb, input bus_ready, bus_rdata);
    modport slave  (input bus_valid, bus_addr, bus_wdata, bus_wstrb, output bus_ready, bus_rdata);
endinterface

// File: rtl/mem_bus_bridge_timeout_counter.sv
// bus_timeout_counter: saturating wait counter that flags the last permitted cycle of a bus request
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned W      = TIMEOUT_CYCLES == 0 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAST_I = TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [W-1:0] LAST  = W'(LAST_I);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (enable && TIMEOUT_CYCLES != 0 && count != '1) count <= count + 1'b1;
    end
    assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST);
endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: single-outstanding CPU memory access to valid/ready bus bridge with hang watchdog
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_fetch,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic [WSTRB_WIDTH-1:0] cpu_wstrb,
    output logic                   cpu_ready,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_fault,
    output logic                   cpu_fault_fetch,
    output logic                   busy,
    mem_bus_bridge_if.master       bus
);
    state_t state, next;
    logic   fetch_q, fault_q, expired, accept;
    assign accept = (state == IDLE) && cpu_req;
    bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  ((state == REQ) && !bus.bus_ready),
        .expired (expired)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next            = state;
        next            = state == IDLE ? (cpu_req ? REQ : IDLE)
                        : state == REQ  ? ((bus.bus_ready || expired) ? DONE : REQ)
                        : IDLE;
        bus.bus_valid   = state == REQ;
        cpu_ready       = state == DONE;
        busy            = state != IDLE;
        cpu_fault       = (state == DONE) && fault_q;
        cpu_fault_fetch = (state == DONE) && fault_q && fetch_q;
    end
    // bus_ready takes priority over a coincident timeout expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_wstrb <= '0;
            fetch_q       <= 1'b0;
            fault_q       <= 1'b0;
            cpu_rdata     <= '0;
        end else if (accept) begin
            bus.bus_addr  <= cpu_addr;
            bus.bus_wdata <= cpu_wdata;
            bus.bus_wstrb <= cpu_wstrb;
            fetch_q       <= cpu_fetch;
        end else if (state == REQ && bus.bus_ready) begin
            fault_q <= 1'b0;
            if (bus.bus_wstrb == '0) cpu_rdata <= bus.bus_rdata;
        end else if (state == REQ && expired) begin
            fault_q   <= 1'b1;
            cpu_rdata <= '0;
        end
    end
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: table-driven accesses with a completion scoreboard plus back-to-back and reset sequences
module tb_mem_bus_bridge;
    import mem_bus_bridge_pkg::*;
    localparam int unsigned TO = 8;
    localparam int NEVER = 255;
    logic        clk = 1'b0, reset = 1'b1, cpu_req = 1'b0, cpu_fetch = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_ready, cpu_fault, cpu_fault_fetch, busy;
    logic [31:0] cpu_rdata;
    int checks = 0, errors = 0;

    mem_bus_bridge_if bus();
    mem_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_req         (cpu_req),
        .cpu_fetch       (cpu_fetch),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_wstrb       (cpu_wstrb),
        .cpu_ready       (cpu_ready),
        .cpu_rdata       (cpu_rdata),
        .cpu_fault       (cpu_fault),
        .cpu_fault_fetch (cpu_fault_fetch),
        .busy            (busy),
        .bus             (bus.master)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic         fetch;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   wstrb;
        int           delay;
        logic [31:0]  rdata_in;
        logic [31:0]  exp_rdata;
        logic         exp_fault;
        fault_cause_t exp_cause;
        int           exp_lat;
    } vec_t;
    typedef struct {
        logic [31:0]  rdata;
        logic         fault;
        logic         fault_fetch;
        fault_cause_t cause;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && cpu_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", cpu_rdata, mon_e.rdata);
                chk("fault", cpu_fault, mon_e.fault);
                chk("fault_fetch", cpu_fault_fetch, mon_e.fault_fetch);
                if (mon_e.fault) chk("fault_cause", fault_cause(cpu_fault_fetch, bus.bus_wstrb), mon_e.cause);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int n, vcyc;
        logic stable;
        cpu_req = 1'b1;
        cpu_fetch = v.fetch;
        cpu_addr = v.addr;
        cpu_wdata = v.wdata;
        cpu_wstrb = v.wstrb;
        sb.push_back('{v.exp_rdata, v.exp_fault, v.exp_fault && v.fetch, v.exp_cause});
        step();
        cpu_req = 1'b0;
        cpu_fetch = ~v.fetch;
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
        cpu_wstrb = 4'hF;
        chk("valid_rise", bus.bus_valid, 1);
        chk("busy", busy, 1);
        chk("bus_addr", bus.bus_addr, v.addr);
        chk("bus_wdata", bus.bus_wdata, v.wdata);
        chk("bus_wstrb", bus.bus_wstrb, v.wstrb);
        n = 1;
        vcyc = 0;
        stable = 1'b1;
        while (!cpu_ready && n < 40) begin
            if (bus.bus_valid) vcyc++;
            if (bus.bus_addr !== v.addr || bus.bus_wdata !== v.wdata || bus.bus_wstrb !== v.wstrb) stable = 1'b0;
            bus.bus_ready = (v.delay != NEVER) && (n == 1 + v.delay);
            bus.bus_rdata = bus.bus_ready ? v.rdata_in : $urandom;
            step();
            n++;
        end
        bus.bus_ready = 1'b0;
        chk("latency", n, v.exp_lat);
        chk("valid_cycles", vcyc, v.delay == NEVER ? TO : v.delay + 1);
        chk("bus_stable", stable, 1);
        chk("valid_drop", bus.bus_valid, 0);
        step();
        chk("ready_pulse", cpu_ready, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev;
        vecs[0] = '{1'b0, 32'h1000_0004, 32'h0, 4'b0000, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, CAUSE_LOAD_FAULT, 5};
        vecs[1] = '{1'b0, 32'h2000_0010, 32'h0000_A5A5, 4'b0011, 0, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, CAUSE_STORE_FAULT, 2};
        vecs[2] = '{1'b1, 32'h0000_0100, 32'h0, 4'b0000, NEVER, 32'h0, 32'h0, 1'b1, CAUSE_INSTR_FAULT, 9};
        vecs[3] = '{1'b0, 32'h3000_0008, 32'h0, 4'b0000, 7, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, CAUSE_LOAD_FAULT, 9};
        vecs[4] = '{1'b0, 32'h4000_0000, 32'hFFFF_0000, 4'b1111, NEVER, 32'h0, 32'h0, 1'b1, CAUSE_STORE_FAULT, 9};
        vecs[5] = '{1'b1, 32'h0000_0104, 32'h0, 4'b0000, 1, 32'h0000_0013, 32'h0000_0013, 1'b0, CAUSE_INSTR_FAULT, 3};
        vecs[6] = '{1'b0, 32'h1000_0008, 32'h0, 4'b0000, 6, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0, CAUSE_LOAD_FAULT, 8};
        vecs[7] = '{1'b0, 32'h5000_0000, 32'h0, 4'b0000, NEVER, 32'h0, 32'h0, 1'b1, CAUSE_LOAD_FAULT, 9};
        bus.bus_ready = 1'b0;
        bus.bus_rdata = '0;
        step();
        step();
        chk("rst_valid", bus.bus_valid, 0);
        chk("rst_ready", cpu_ready, 0);
        chk("rst_fault", cpu_fault, 0);
        chk("rst_fault_fetch", cpu_fault_fetch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_addr", bus.bus_addr, 0);
        chk("rst_wdata", bus.bus_wdata, 0);
        chk("rst_wstrb", bus.bus_wstrb, 0);
        reset = 1'b0;
        step();
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        cpu_req = 1'b1;
        cpu_wstrb = 4'b0000;
        cpu_fetch = 1'b0;
        bus.bus_ready = 1'b1;
        bus.bus_rdata = 32'h0BAD_F00D;
        prev = bus.bus_addr;
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) sb.push_back('{32'h0BAD_F00D, 1'b0, 1'b0, CAUSE_LOAD_FAULT});
            cpu_addr = 32'h7000_0000 + 32'(i * 4);
            chk("b2b_valid", bus.bus_valid, 32'(i % 3 == 1));
            chk("b2b_ready", cpu_ready, 32'(i % 3 == 2));
            if (i % 3 == 1) chk("b2b_addr", bus.bus_addr, 32'h7000_0000 + 32'((i - 1) * 4));
            else chk("b2b_addr_hold", bus.bus_addr, prev);
            prev = bus.bus_addr;
            step();
        end
        cpu_req = 1'b0;
        bus.bus_ready = 1'b0;
        cpu_req = 1'b1;
        cpu_addr = 32'h6000_0000;
        step();
        cpu_req = 1'b0;
        chk("rstreq_valid", bus.bus_valid, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstreq_valid_drop", bus.bus_valid, 0);
        chk("rstreq_busy", busy, 0);
        chk("rstreq_addr", bus.bus_addr, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rstreq_no_ready", cpu_ready, 0);
            step();
        end
        run_vec(vecs[0]);
        step();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Single-outstanding memory access bridge that sits directly downstream of the datapath's memory port (address, write data, byte strobes). It turns a control-unit access request into a valid/ready bus transaction toward the SoC interconnect. It returns read data and a one-cycle completion pulse to the control unit. A watchdog converts a hung bus access into a reportable access fault instead of a CPU lockup.

## Interface
- TIMEOUT_CYCLES, 255, cycles a request may wait for `bus_ready` before it is aborted; 0 disables the timeout
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  access request from control unit; sampled only in IDLE
- cpu_fetch  in  1  access is an instruction fetch; sampled with cpu_req
- cpu_addr  in  32  byte address, taken from the datapath memory address mux
- cpu_wdata  in  32  aligned store data from store alignment
- cpu_wstrb  in  4  byte enables; 4'b0000 = load/fetch, non-zero = store
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  captured read word, held until the next completed load
- cpu_fault  out  1  asserted with cpu_ready when the access timed out
- cpu_fault_fetch  out  1  copy of the captured cpu_fetch, valid while cpu_fault=1
- busy  out  1  high in any state other than IDLE
- bus_valid  out  1  request valid toward interconnect
- bus_addr  out  32  registered address
- bus_wdata  out  32  registered write data
- bus_wstrb  out  4  registered byte enables
- bus_ready  in  1  interconnect completion
- bus_rdata  in  32  read data, valid when bus_ready=1

## Operation
- States: IDLE, REQ, DONE.
- IDLE, cpu_req=1:
  - Capture addr, wdata, wstrb and fetch into registers.
  - Clear the timeout counter.
  - Go to REQ.
- IDLE, cpu_req=0: stay in IDLE.
- REQ:
  - bus_valid=1; bus_addr/wdata/wstrb stay stable for the whole state.
  - On bus_ready=1: if the captured wstrb==0, cpu_rdata<=bus_rdata, otherwise cpu_rdata is unchanged. Go to DONE with fault=0.
  - On no bus_ready: counter increments. When the counter reaches TIMEOUT_CYCLES-1 (with TIMEOUT_CYCLES≠0), go to DONE with fault=1 and cpu_rdata<=32'h0.
  - If bus_ready and the timeout expiry fall in the same cycle, bus_ready wins and no fault is raised.
- DONE:
  - cpu_ready=1 and cpu_fault=registered fault for exactly one cycle.
  - Return to IDLE.
- cpu_req asserted in REQ or DONE is ignored. The control unit must re-request after cpu_ready.
- Stores update no read state. A store fault still returns cpu_rdata=0.
- The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates. With TIMEOUT_CYCLES=0 it never counts.
- No address alignment checks; misalignment is flagged upstream.

## Timing
- Reset values: state=IDLE; bus_valid=0; cpu_ready=0; cpu_fault=0; cpu_fault_fetch=0; busy=0; cpu_rdata, bus_addr, bus_wdata all 0; bus_wstrb=0; counter=0.
- Request latency: cpu_req in cycle 0 → bus_valid=1 in cycle 1.
- Completion latency: bus_ready in cycle k (k≥1) → cpu_ready in cycle k+1, cpu_rdata valid from cycle k+1. Minimum round trip is 2 cycles.
- Back-to-back: cpu_req may be asserted in the cycle after cpu_ready, giving a new bus_valid one cycle later. The throughput limit is one access per 3 cycles.
- Timeout: bus_valid is high for exactly TIMEOUT_CYCLES cycles. It drops in the cycle cpu_ready/cpu_fault pulse.
- Reset mid-transaction: bus_valid=0 in the cycle after reset is sampled and no cpu_ready is issued. The interconnect must tolerate an abandoned request.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - WSTRB_WIDTH=4;
  - the fault cause value for the exception handler (load/store/instruction access fault, selected by cpu_fault_fetch and wstrb).
- One module. The timeout watchdog is a natural sub-module, `bus_timeout_counter` (clear, enable, expired). The bridge FSM and capture registers stay in the top.

## Test plan
- Load, cpu_addr=32'h1000_0004, bus_ready 3 cycles after bus_valid, bus_rdata=32'hDEAD_BEEF → cpu_ready at cycle 5, cpu_rdata=32'hDEAD_BEEF, cpu_fault=0.
- Store, wstrb=4'b0011, wdata=32'h0000_A5A5, immediate bus_ready → bus_wstrb=4'b0011 while bus_valid; cpu_ready at cycle 2; cpu_rdata keeps its previous value.
- TIMEOUT_CYCLES=8, fetch, never ready → bus_valid high 8 cycles; cpu_ready=cpu_fault=cpu_fault_fetch=1 in one cycle; cpu_rdata=0.
- TIMEOUT_CYCLES=8, bus_ready arriving exactly on the 8th waiting cycle → normal completion, cpu_fault=0.
- cpu_req held high continuously with bus_ready=1 every cycle → exactly one cpu_ready every 3 cycles; bus_addr changes only in IDLE→REQ transitions.
- reset asserted in REQ → next cycle bus_valid=0, busy=0, no cpu_ready. A subsequent request completes normally.
